// File: rtl/puf_response_collector.sv
// Gathers NUM_WORDS majority-voted PUF words along an external LFSR challenge
// sequence and counts bits that disagreed between votes.
module puf_response_collector #(
    parameter int unsigned WORD_W    = 16,
    parameter int unsigned NUM_WORDS = 8,
    parameter int unsigned VOTES     = 1,
    parameter int unsigned SETTLE    = 1
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  start,
    input  logic [WORD_W-1:0]                     seed,
    output logic                                  lfsr_load,
    output logic [WORD_W-1:0]                     lfsr_seed,
    output logic                                  lfsr_next,
    input  logic                                  lfsr_ready,
    input  logic [WORD_W-1:0]                     puf_resp,
    output logic                                  busy,
    output logic                                  resp_valid,
    output logic [WORD_W*NUM_WORDS-1:0]           resp_out,
    output logic [$clog2(WORD_W*NUM_WORDS+1)-1:0] err_cnt
);

    localparam int unsigned RESP_W = WORD_W * NUM_WORDS;
    localparam int unsigned ERR_W  = $clog2(RESP_W + 1);
    localparam int unsigned CNT_W  = $clog2(VOTES + 1);
    localparam int unsigned UNS_W  = $clog2(WORD_W + 1);
    localparam int unsigned IDX_W  = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int unsigned VOT_W  = (VOTES > 1) ? $clog2(VOTES) : 1;
    localparam int unsigned SET_W  = $clog2(SETTLE + 2);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_LOADW    = 3'd1;
    localparam logic [2:0] S_WAIT_RDY = 3'd2;
    localparam logic [2:0] S_SETTLE   = 3'd3;
    localparam logic [2:0] S_SAMPLE   = 3'd4;
    localparam logic [2:0] S_ADVW     = 3'd5;
    localparam logic [2:0] S_DONE     = 3'd6;

    generate
        if ((VOTES % 2) == 0 || NUM_WORDS < 1) begin : g_bad_params
            $error("puf_response_collector: VOTES must be odd and NUM_WORDS must be >= 1");
        end
    endgenerate

    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic [IDX_W-1:0] word_idx;
    logic [VOT_W-1:0] vote_cnt;
    logic [SET_W-1:0] settle_cnt;
    logic [CNT_W-1:0] ones     [WORD_W];
    logic [CNT_W-1:0] ones_sum [WORD_W];
    logic [WORD_W-1:0] voted_word;
    logic [UNS_W-1:0] unstable_cnt;
    logic [ERR_W:0]   err_sum;
    logic [ERR_W-1:0] err_nxt;
    logic             sample_last;
    logic             word_last;

    assign sample_last = (state == S_SAMPLE) && (vote_cnt == VOT_W'(VOTES - 1));
    assign word_last   = (word_idx == IDX_W'(NUM_WORDS - 1));

    // Per-bit vote including the current sample, plus saturating error accumulation
    always_comb begin
        ones_sum     = '{default: '0};
        voted_word   = '0;
        unstable_cnt = '0;
        for (int b = 0; b < int'(WORD_W); b++) begin
            ones_sum[b]   = ones[b] + CNT_W'(puf_resp[b]);
            voted_word[b] = (ones_sum[b] > CNT_W'(VOTES / 2));
            if ((ones_sum[b] != '0) && (ones_sum[b] != CNT_W'(VOTES))) begin
                unstable_cnt = unstable_cnt + UNS_W'(1);
            end
        end
        err_sum = {1'b0, err_cnt} + (ERR_W + 1)'(unstable_cnt);
        err_nxt = err_sum[ERR_W] ? '1 : err_sum[ERR_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_nxt = S_LOADW;
                end
            end
            // LFSR drops ready right after a pulse, so these never look at it
            S_LOADW, S_ADVW: state_nxt = S_WAIT_RDY;
            S_WAIT_RDY: begin
                if (lfsr_ready) begin
                    state_nxt = (SETTLE == 0) ? S_SAMPLE : S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (settle_cnt == '0) begin
                    state_nxt = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                if (sample_last) begin
                    state_nxt = word_last ? S_DONE : S_ADVW;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Registered outputs decoded from the next state, plus the collection datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_load  <= 1'b0;
            lfsr_next  <= 1'b0;
            lfsr_seed  <= '0;
            busy       <= 1'b0;
            resp_valid <= 1'b0;
            resp_out   <= '0;
            err_cnt    <= '0;
            word_idx   <= '0;
            vote_cnt   <= '0;
            settle_cnt <= '0;
            for (int b = 0; b < int'(WORD_W); b++) begin
                ones[b] <= '0;
            end
        end else begin
            lfsr_load  <= (state_nxt == S_LOADW);
            lfsr_next  <= (state_nxt == S_ADVW);
            busy       <= (state_nxt != S_IDLE) && (state_nxt != S_DONE);
            resp_valid <= (state_nxt == S_DONE);
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        lfsr_seed <= seed;
                        resp_out  <= '0;
                        err_cnt   <= '0;
                        word_idx  <= '0;
                        vote_cnt  <= '0;
                        for (int b = 0; b < int'(WORD_W); b++) begin
                            ones[b] <= '0;
                        end
                    end
                end
                S_WAIT_RDY: begin
                    if (lfsr_ready) begin
                        settle_cnt <= SET_W'(SETTLE - 1);
                    end
                end
                S_SETTLE: begin
                    if (settle_cnt != '0) begin
                        settle_cnt <= settle_cnt - SET_W'(1);
                    end
                end
                S_SAMPLE: begin
                    if (sample_last) begin
                        vote_cnt <= '0;
                        err_cnt  <= err_nxt;
                        for (int b = 0; b < int'(WORD_W); b++) begin
                            ones[b] <= '0;
                        end
                        // Word 0 lands in the MSBs
                        for (int w = 0; w < int'(NUM_WORDS); w++) begin
                            if (word_idx == IDX_W'(w)) begin
                                resp_out[(int'(NUM_WORDS) - w) * int'(WORD_W) - 1 -: WORD_W] <= voted_word;
                            end
                        end
                        if (!word_last) begin
                            word_idx <= word_idx + IDX_W'(1);
                        end
                    end else begin
                        vote_cnt <= vote_cnt + VOT_W'(1);
                        for (int b = 0; b < int'(WORD_W); b++) begin
                            ones[b] <= ones_sum[b];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/puf_response_collector.md
Name: puf_response_collector

Overview:
- Parametrised successor of the fixed 128-bit PUF response gatherer.
- Drives an external LFSR challenge generator (seed load, advance, ready handshake) and samples a WORD_W-bit PUF response once per challenge.
- Each challenge is evaluated VOTES times and majority-voted per bit; NUM_WORDS voted words are concatenated into one response.
- Counts unstable bits, supports restart on demand, and feeds key generation / authentication logic.

Parameters:
- WORD_W, 16, PUF/LFSR word width in bits.
- NUM_WORDS, 8, words collected per run; response width = WORD_W*NUM_WORDS.
- VOTES, 1, evaluations per challenge; odd, >=1.
- SETTLE, 1, idle cycles between lfsr_ready and first sample; 0 allowed.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a run; accepted only in IDLE or DONE.
- seed  in  WORD_W  challenge seed, latched when start is accepted.
- lfsr_load  out  1  one-cycle pulse: LFSR loads lfsr_seed.
- lfsr_seed  out  WORD_W  latched seed.
- lfsr_next  out  1  one-cycle pulse: LFSR advances.
- lfsr_ready  in  1  LFSR challenge stable; LFSR drops it the cycle after load/next and reasserts when the new challenge is stable.
- puf_resp  in  WORD_W  PUF response to the current challenge.
- busy  out  1  run in progress.
- resp_valid  out  1  level: resp_out complete.
- resp_out  out  WORD_W*NUM_WORDS  voted response; word 0 in MSBs.
- err_cnt  out  $clog2(WORD_W*NUM_WORDS+1)  total unstable bits in last run.

Behaviour:
- Reset: all outputs 0, lfsr_seed 0, state IDLE. Reset mid-run aborts immediately with no further LFSR pulses.
- IDLE / DONE, start=1: same edge latches seed, clears resp_out, err_cnt, resp_valid and word_idx, sets busy=1, pulses lfsr_load for 1 cycle, goes to LOADW.
- start is ignored while busy=1.
- LOADW / ADVW: always 1 cycle, ignoring lfsr_ready (covers the LFSR ready drop), then WAIT_RDY.
- WAIT_RDY: hold until lfsr_ready=1.
  - Then go to SETTLE, loading counter=SETTLE-1.
  - If SETTLE=0, go straight to SAMPLE.
- SETTLE: decrement; at 0 go to SAMPLE.
- SAMPLE: lasts exactly VOTES cycles.
  - Per-bit ones counters (width $clog2(VOTES+1)) accumulate puf_resp each cycle.
  - On the edge ending the last SAMPLE cycle:
    - voted bit = ones > VOTES/2.
    - Bit is unstable if 0 < ones < VOTES.
    - err_cnt += unstable count for the word, saturating at all-ones.
    - Voted word written to resp_out[(NUM_WORDS-word_idx)*WORD_W-1 -: WORD_W].
    - Counters cleared.
  - If word_idx==NUM_WORDS-1: go to DONE.
  - Else: word_idx++, pulse lfsr_next 1 cycle, go to ADVW.
- DONE: busy=0, resp_valid=1. resp_out and err_cnt hold until next accepted start or rst.
- VOTES=1: err_cnt always 0.
- Per-word cycles, ready already high on WAIT_RDY entry: 1 (WAIT_RDY) + SETTLE + VOTES, plus 1 (ADVW) for non-last words.
- Load overhead: 1 (IDLE accept) + 1 (LOADW).
- lfsr_load and lfsr_next are never high in the same cycle.
- Elaboration error if VOTES is even or NUM_WORDS<1.

Test Plan:
- Defaults, LFSR model raises ready 2 cycles after each pulse, puf_resp=16'h1234 constant, seed=16'hACE1 -> exactly 1 lfsr_load, then 7 lfsr_next; resp_out={8{16'h1234}}; err_cnt=0; resp_valid=1, busy=0 after the run.
- puf_resp = challenge (LFSR x^16+x^14+x^13+x^11, seed 16'hACE1) -> resp_out equals the 8 successive LFSR states, first state in bits [127:112].
- VOTES=3, puf_resp toggles bit0 between two of three samples per word, other bits constant 16'h00F0 -> voted words keep majority bit0; err_cnt=8.
- lfsr_ready held low 20 cycles on word 3 -> FSM waits in WAIT_RDY with no extra pulses; final resp_out is unchanged versus the no-stall run.
- rst asserted during word 4, then start with a new seed -> all outputs 0 the cycle after rst; new run completes with only new data; start pulses while busy are ignored.
- In DONE, start again with seed 16'h0001 -> resp_valid drops on accept; new response replaces the old one; err_cnt restarts from 0.
